// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO geometry and data type for the 16x8 FIFO, its stream reader and benches.
package fifo_pkg;
  localparam int FIFO_DW = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int RD_BUF_DEPTH = 2;
  localparam int WORDS_CNT_W = 16;
  typedef logic [FIFO_DW-1:0] fifo_data_t;
endpackage

// File: rtl/fifo_rd_buf.sv
// fifo_rd_buf: circular output buffer with occupancy count; head word is always presented.
module fifo_rd_buf
  import fifo_pkg::*;
#(
  parameter int DW = FIFO_DW,
  parameter int DEPTH = RD_BUF_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [DW-1:0] i_din,
  input  logic          i_pop,
  output logic [CW-1:0] o_count,
  output logic [DW-1:0] o_data
);
  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + 1'b1;
      if (i_pop) r_head <= r_head + 1'b1;
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_tail] <= i_din;
  end
  // The issuer's credit check guarantees the buffer never overfills.
  always_ff @(posedge clk) begin
    if (!rst) assert (r_count <= CW'(DEPTH));
  end
  assign o_count = r_count;
  assign o_data  = r_mem[r_head];
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pops the FIFO ahead of demand and hides its registered read latency,
// presenting a one-word-per-cycle valid/ready stream.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DW = FIFO_DW,
  parameter int BUF_DEPTH = RD_BUF_DEPTH,
  parameter int CNT_W = WORDS_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_fifo_empty,
  input  logic             i_fifo_wr_grant,
  input  logic [DW-1:0]    i_fifo_dout,
  output logic             o_fifo_rd_en,
  output logic             o_m_valid,
  input  logic             i_m_ready,
  output logic [DW-1:0]    o_m_data,
  output logic [CNT_W-1:0] o_words_out,
  output logic             o_busy
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  logic             r_inflight;
  logic [CNT_W-1:0] r_words;
  logic [CW-1:0]    w_count;
  logic [CW:0]      w_occ;
  logic             w_fire, w_pop_ok;
  fifo_rd_buf #(.DW(DW), .DEPTH(BUF_DEPTH)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_inflight),
    .i_din   (i_fifo_dout),
    .i_pop   (w_fire),
    .o_count (w_count),
    .o_data  (o_m_data)
  );
  assign o_m_valid = w_count != '0;
  assign w_fire = o_m_valid && i_m_ready;
  // A word leaving this cycle frees its slot for a pop issued this same cycle.
  assign w_occ = {1'b0, w_count} + (CW+1)'(r_inflight) - (CW+1)'(w_fire);
  assign o_fifo_rd_en = !rst && !i_fifo_empty && w_occ < (CW+1)'(BUF_DEPTH);
  assign w_pop_ok = o_fifo_rd_en && !i_fifo_wr_grant;
  assign o_busy = o_m_valid || r_inflight;
  assign o_words_out = r_words;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight <= 1'b0;
      r_words    <= '0;
    end else begin
      r_inflight <= w_pop_ok;
      if (w_fire) r_words <= r_words + 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: behavioural 16x8 FIFO in front of the reader, scoreboard on the stream side.
module tb_fifo_stream_reader;
  import fifo_pkg::*;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  logic fifo_empty, fifo_wr_grant, fifo_rd_en, m_valid, busy;
  logic m_ready = 0, wr_en = 0, flush = 0;
  fifo_data_t fifo_dout = '0, wr_data = '0, m_data, held = '0;
  logic [WORDS_CNT_W-1:0] words_out;
  fifo_data_t fq[$];
  fifo_data_t exp_q[$];
  int fcnt = 0, cyc = 0, pops = 0, shadows = 0, n_fired = 0;
  int first_pop = -1, first_valid = -1, first_fire = -1, last_fire = -1;
  int n_tests = 0, n_fail = 0;
  logic stall = 0;
  assign fifo_empty = fcnt == 0;
  assign fifo_wr_grant = wr_en && fcnt < FIFO_DEPTH;

  fifo_stream_reader dut (
    .clk             (clk),
    .rst             (rst),
    .i_fifo_empty    (fifo_empty),
    .i_fifo_wr_grant (fifo_wr_grant),
    .i_fifo_dout     (fifo_dout),
    .o_fifo_rd_en    (fifo_rd_en),
    .o_m_valid       (m_valid),
    .i_m_ready       (m_ready),
    .o_m_data        (m_data),
    .o_words_out     (words_out),
    .o_busy          (busy)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // FIFO model: writes win over reads, read data registered one cycle after the pop.
  always @(posedge clk) begin
    if (flush) begin
      fq.delete();
      fcnt <= 0;
    end else begin
      if (fifo_rd_en && fifo_wr_grant) shadows++;
      if (fifo_wr_grant) begin
        fq.push_back(wr_data);
        fcnt <= fcnt + 1;
      end else if (fifo_rd_en && fcnt > 0) begin
        fifo_dout <= fq.pop_front();
        fcnt <= fcnt - 1;
        pops++;
        if (first_pop < 0) first_pop = cyc;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (rst) begin
      n_fired = 0;
      stall = 0;
    end else begin
      if (stall) begin
        chk("hold_valid", 32'(m_valid), 1);
        chk("hold_data", 32'(m_data), 32'(held));
      end
      if (m_valid && first_valid < 0) first_valid = cyc;
      if (m_valid && m_ready) begin
        chk("sb_nonempty", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("m_data", 32'(m_data), 32'(exp_q.pop_front()));
        chk("words_out_run", 32'(words_out), n_fired);
        n_fired++;
        if (first_fire < 0) first_fire = cyc;
        last_fire = cyc;
      end
      stall = m_valid && !m_ready;
      held = m_data;
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(fifo_data_t d);
    wr_en = 1;
    wr_data = d;
    exp_q.push_back(d);
    tick();
    wr_en = 0;
  endtask

  task automatic drain(string name);
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < 300) begin
      tick();
      k++;
    end
    chk(name, 32'(k < 300), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    tick(2);
    chk("rst_rd_en", 32'(fifo_rd_en), 0);
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_words", 32'(words_out), 0);
    m_ready = 1;
    wr(8'h11);
    wr(8'h22);
    wr(8'h33);
    chk("rst_blocks_pop", 32'(fifo_rd_en), 0);
    first_pop = -1;
    first_valid = -1;
    first_fire = -1;
    rst = 0;
    drain("t2_drain");
    chk("t2_latency", first_valid - first_pop, 2);
    chk("t2_back_to_back", last_fire - first_fire, 2);
    chk("t2_words", 32'(words_out), 3);

    m_ready = 0;
    for (int i = 0; i < 16; i++) wr(fifo_data_t'(i));
    pops = 0;
    tick(6);
    chk("t3_pops", pops, 2);
    chk("t3_valid", 32'(m_valid), 1);
    chk("t3_data", 32'(m_data), 0);
    chk("t3_busy", 32'(busy), 1);
    m_ready = 1;
    first_fire = -1;
    drain("t3_drain");
    chk("t3_stream", last_fire - first_fire, 15);
    chk("t3_words", 32'(words_out), 19);

    shadows = 0;
    wr(8'h40);
    wr(8'h41);
    tick();
    wr(8'h42);
    drain("t4_drain");
    chk("t4_shadowed", 32'(shadows > 0), 1);
    chk("t4_words", 32'(words_out), 22);

    for (int i = 0; i < 8; i++) wr(fifo_data_t'(8'hA0 + i));
    for (int i = 0; i < 60 && (exp_q.size() != 0 || busy); i++) begin
      m_ready = (i % 2) == 0;
      tick();
    end
    chk("t5_drained", exp_q.size(), 0);
    chk("t5_words", 32'(words_out), 30);

    m_ready = 0;
    wr(8'h61);
    wr(8'h62);
    wr(8'h63);
    wr(8'h64);
    tick(2);
    chk("t6_busy_pre", 32'(busy), 1);
    rst = 1;
    flush = 1;
    exp_q.delete();
    #1;
    chk("t6_rd_en_in_rst", 32'(fifo_rd_en), 0);
    tick();
    flush = 0;
    chk("t6_valid", 32'(m_valid), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_words", 32'(words_out), 0);
    chk("t6_rd_en", 32'(fifo_rd_en), 0);
    rst = 0;
    m_ready = 1;
    wr(8'h5A);
    drain("t6_after_drain");
    chk("t6_after_words", 32'(words_out), 1);
    chk("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
